// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the Sloth ID/EX stage: condition codes, EX command
// encodings, NZCV bit positions and the bubble control word.
package id_ex_stage_reg_pkg;

  // ARM condition field encodings (instruction bits [31:28])
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // EX command encodings produced by the control unit. Several opcodes share
  // an ALU operation (CMP is a SUB, TST an AND, LDR/STR an address ADD).
  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_CMP = 4'b0100;
  localparam logic [3:0] EX_TST = 4'b0110;
  localparam logic [3:0] EX_LDR = 4'b0010;
  localparam logic [3:0] EX_STR = 4'b0010;

  // NZCV bit positions inside the 4-bit status word
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Registered control word travelling from ID into EX
  typedef struct packed {
    logic [3:0] ex_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // A bubble must not write memory, registers, flags or redirect the PC
  localparam ctrl_t BUBBLE_CTRL = '{
    ex_cmd:    EX_NOP,
    mem_read:  1'b0,
    mem_write: 1'b0,
    wb_en:     1'b0,
    b:         1'b0,
    s:         1'b0
  };

  // True when the instruction sitting in EX will update NZCV
  function automatic logic flag_write(input logic valid, input logic s);
    return valid & s;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Bundle of the ID-side inputs, hazard/flush controls, ALU flag feedback and
// the registered EX-side outputs of the ID/EX stage register.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);

  // pipeline control
  logic              stall;
  logic              flush;
  logic              hazard;

  // instruction leaving decode
  logic              id_valid;
  logic [3:0]        id_cond;
  logic [3:0]        id_ex_cmd;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_wb_en;
  logic              id_b;
  logic              id_s;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_val_rn;
  logic [DATA_W-1:0] id_val_rm;
  logic              id_imm;
  logic [11:0]       id_shift_op;
  logic [23:0]       id_simm24;
  logic [REG_W-1:0]  id_dest;
  logic [REG_W-1:0]  id_src1;
  logic [REG_W-1:0]  id_src2;

  // flags computed by the ALU for the instruction currently in EX
  logic [3:0]        alu_status;

  // instruction entering execute
  logic              ex_valid;
  logic [3:0]        ex_ex_cmd;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_wb_en;
  logic              ex_b;
  logic              ex_s;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_val_rn;
  logic [DATA_W-1:0] ex_val_rm;
  logic              ex_imm;
  logic [11:0]       ex_shift_op;
  logic [23:0]       ex_simm24;
  logic [REG_W-1:0]  ex_dest;
  logic [REG_W-1:0]  ex_src1;
  logic [REG_W-1:0]  ex_src2;

  // architectural flags and the ID condition result
  logic [3:0]        status;
  logic              cond_pass;

  // decode / hazard side: drives the stage inputs, observes its outputs
  modport master (
    output stall, flush, hazard,
    output id_valid, id_cond, id_ex_cmd, id_mem_read, id_mem_write,
    output id_wb_en, id_b, id_s, id_pc, id_val_rn, id_val_rm, id_imm,
    output id_shift_op, id_simm24, id_dest, id_src1, id_src2,
    output alu_status,
    input  ex_valid, ex_ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
    input  ex_b, ex_s, ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_op,
    input  ex_simm24, ex_dest, ex_src1, ex_src2,
    input  status, cond_pass
  );

  // the stage register itself
  modport slave (
    input  stall, flush, hazard,
    input  id_valid, id_cond, id_ex_cmd, id_mem_read, id_mem_write,
    input  id_wb_en, id_b, id_s, id_pc, id_val_rn, id_val_rm, id_imm,
    input  id_shift_op, id_simm24, id_dest, id_src1, id_src2,
    input  alu_status,
    output ex_valid, ex_ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
    output ex_b, ex_s, ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_op,
    output ex_simm24, ex_dest, ex_src1, ex_src2,
    output status, cond_pass
  );

endinterface

// File: rtl/id_ex_stage_reg_cond_check.sv
// Purely combinational ARM condition evaluator. Shared with the branch unit,
// so it takes the flag word explicitly rather than reading any register.
module cond_check
  import id_ex_stage_reg_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  // Decode the condition field against the supplied flags; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the Sloth core. Owns NZCV, evaluates the ID
// instruction's condition (with flag forwarding from EX) and turns failed,
// flushed, hazarded or empty slots into bubbles before they reach EX.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_stage_reg_if.slave bus
);

  // stage-1 state: valid, control word, operand fields, flags
  logic              vld_p1;
  ctrl_t             ctrl_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] val_rn_p1;
  logic [DATA_W-1:0] val_rm_p1;
  logic              imm_p1;
  logic [11:0]       shift_op_p1;
  logic [23:0]       simm24_p1;
  logic [REG_W-1:0]  dest_p1;
  logic [REG_W-1:0]  src1_p1;
  logic [REG_W-1:0]  src2_p1;
  logic [3:0]        status_q;

  // stage-0 (ID side) combinational signals
  logic              ex_flag_write;
  logic [3:0]        eff_flags;
  logic              pass;
  logic              load_live;
  ctrl_t             id_ctrl;
  ctrl_t             ctrl_d;

  // A flag-setting instruction in EX has not written status yet, so the
  // ID instruction must see its ALU flags directly.
  assign ex_flag_write = flag_write(vld_p1, ctrl_p1.s);
  assign eff_flags     = ex_flag_write ? bus.alu_status : status_q;

  cond_check u_cond_check (
    .cond (bus.id_cond),
    .nzcv (eff_flags),
    .pass (pass)
  );

  // Choose between the decoded control word and a bubble
  always_comb begin
    id_ctrl   = '{
      ex_cmd:    bus.id_ex_cmd,
      mem_read:  bus.id_mem_read,
      mem_write: bus.id_mem_write,
      wb_en:     bus.id_wb_en,
      b:         bus.id_b,
      s:         bus.id_s
    };
    load_live = bus.id_valid & pass & ~bus.flush & ~bus.hazard;
    ctrl_d    = load_live ? id_ctrl : BUBBLE_CTRL;
  end

  // ---- ID -> EX boundary ----

  // Control half of the stage: stall holds, otherwise live word or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= BUBBLE_CTRL;
    end else if (!bus.stall) begin
      vld_p1  <= load_live;
      ctrl_p1 <= ctrl_d;
    end
  end

  // Operand half: loads whenever not stalled, even for bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1       <= '0;
      val_rn_p1   <= '0;
      val_rm_p1   <= '0;
      imm_p1      <= 1'b0;
      shift_op_p1 <= '0;
      simm24_p1   <= '0;
      dest_p1     <= '0;
      src1_p1     <= '0;
      src2_p1     <= '0;
    end else if (!bus.stall) begin
      pc_p1       <= bus.id_pc;
      val_rn_p1   <= bus.id_val_rn;
      val_rm_p1   <= bus.id_val_rm;
      imm_p1      <= bus.id_imm;
      shift_op_p1 <= bus.id_shift_op;
      simm24_p1   <= bus.id_simm24;
      dest_p1     <= bus.id_dest;
      src1_p1     <= bus.id_src1;
      src2_p1     <= bus.id_src2;
    end
  end

  // Commit EX flags; flush does not block it because EX is the older,
  // architecturally live instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
    end else if (ex_flag_write && !bus.stall) begin
      status_q <= bus.alu_status;
    end
  end

  assign bus.ex_valid     = vld_p1;
  assign bus.ex_ex_cmd    = ctrl_p1.ex_cmd;
  assign bus.ex_mem_read  = ctrl_p1.mem_read;
  assign bus.ex_mem_write = ctrl_p1.mem_write;
  assign bus.ex_wb_en     = ctrl_p1.wb_en;
  assign bus.ex_b         = ctrl_p1.b;
  assign bus.ex_s         = ctrl_p1.s;
  assign bus.ex_pc        = pc_p1;
  assign bus.ex_val_rn    = val_rn_p1;
  assign bus.ex_val_rm    = val_rm_p1;
  assign bus.ex_imm       = imm_p1;
  assign bus.ex_shift_op  = shift_op_p1;
  assign bus.ex_simm24    = simm24_p1;
  assign bus.ex_dest      = dest_p1;
  assign bus.ex_src1      = src1_p1;
  assign bus.ex_src2      = src2_p1;
  assign bus.status       = status_q;
  assign bus.cond_pass    = pass;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for the ID/EX stage register: reset, flag forwarding,
// condition nullification, stall/flush/hazard priority and the full
// condition table.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam logic [4:0] CTL_NONE = 5'b00000; // {mr, mw, wb, b, s}
  localparam logic [4:0] CTL_WB   = 5'b00100;
  localparam logic [4:0] CTL_MW   = 5'b01000;
  localparam logic [4:0] CTL_S    = 5'b00001;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] exp_tab;

  id_ex_stage_reg_if #(.DATA_W(32), .REG_W(4)) bus ();

  id_ex_stage_reg #(.DATA_W(32), .REG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cond, input logic [3:0] cmd,
                       input logic [4:0] ctl, input logic [31:0] pc);
    bus.id_valid    = v;
    bus.id_cond     = cond;
    bus.id_ex_cmd   = cmd;
    {bus.id_mem_read, bus.id_mem_write, bus.id_wb_en, bus.id_b, bus.id_s} = ctl;
    bus.id_pc       = pc;
    bus.id_val_rn   = pc ^ 32'hA5A5_0000;
    bus.id_val_rm   = pc + 32'd8;
    bus.id_imm      = pc[2];
    bus.id_shift_op = pc[11:0];
    bus.id_simm24   = pc[23:0];
    bus.id_dest     = pc[3:0];
    bus.id_src1     = pc[7:4];
    bus.id_src2     = pc[11:8];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_tab = 16'h565A; // pass bits for eff NZCV = 1001, indexed by cond
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.hazard = 1'b0;
    bus.alu_status = 4'b0000;
    drive(1'b0, COND_AL, EX_NOP, CTL_NONE, 32'h0);

    // reset state
    #2;
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_wb", bus.ex_wb_en, 0);
    chk("rst_status", bus.status, 0);
    #1 rst_n = 1'b1;

    // plain ADD loads after one edge
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h104);
    step();
    chk("add_valid", bus.ex_valid, 1);
    chk("add_wb", bus.ex_wb_en, 1);
    chk("add_cmd", bus.ex_ex_cmd, 32'h2);
    chk("add_pc", bus.ex_pc, 32'h104);
    chk("add_rn", bus.ex_val_rn, 32'hA5A50104);
    chk("add_dest", bus.ex_dest, 32'h4);

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_wb", bus.ex_wb_en, 0);
    chk("arst_pc", bus.ex_pc, 0);
    chk("arst_status", bus.status, 0);
    #1 rst_n = 1'b1;

    // forwarding: CMP S=1 in EX, MOVEQ in ID
    drive(1'b1, COND_AL, EX_CMP, CTL_S, 32'h108);
    step();
    chk("cmp_s", bus.ex_s, 1);
    chk("cmp_valid", bus.ex_valid, 1);
    bus.alu_status = 4'b0100;
    drive(1'b1, COND_EQ, EX_MOV, CTL_WB, 32'h10C);
    #1;
    chk("fwd_pass", bus.cond_pass, 1);
    step();
    chk("fwd_valid", bus.ex_valid, 1);
    chk("fwd_wb", bus.ex_wb_en, 1);
    chk("fwd_cmd", bus.ex_ex_cmd, 32'h1);
    chk("fwd_status", bus.status, 32'h4);

    // nullify: STRNE with Z=1
    bus.alu_status = 4'b0000;
    drive(1'b1, COND_NE, EX_STR, CTL_MW, 32'h110);
    #1;
    chk("null_pass", bus.cond_pass, 0);
    step();
    chk("null_valid", bus.ex_valid, 0);
    chk("null_mw", bus.ex_mem_write, 0);
    chk("null_status", bus.status, 32'h4);

    // stall for three cycles with a flag-setting instruction in EX
    drive(1'b1, COND_AL, EX_CMP, CTL_S, 32'h114);
    step();
    chk("stl_pre_s", bus.ex_s, 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_status = 4'b1000 ^ 4'(i);
      drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h200 + 32'(4 * i));
      step();
      chk("stl_pc", bus.ex_pc, 32'h114);
      chk("stl_s", bus.ex_s, 1);
      chk("stl_wb", bus.ex_wb_en, 0);
      chk("stl_status", bus.status, 32'h4);
    end
    bus.stall = 1'b0;
    bus.alu_status = 4'b0010;
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h300);
    step();
    chk("rel_pc", bus.ex_pc, 32'h300);
    chk("rel_wb", bus.ex_wb_en, 1);
    chk("rel_s", bus.ex_s, 0);
    chk("rel_status", bus.status, 32'h2);

    // flush + hazard gives one bubble
    bus.flush = 1'b1;
    bus.hazard = 1'b1;
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h304);
    step();
    chk("fh_valid", bus.ex_valid, 0);
    chk("fh_wb", bus.ex_wb_en, 0);
    chk("fh_cmd", bus.ex_ex_cmd, 0);
    bus.flush = 1'b0;

    // hazard alone
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h308);
    step();
    chk("hz_valid", bus.ex_valid, 0);
    bus.hazard = 1'b0;

    // empty ID slot
    drive(1'b0, COND_AL, EX_ADD, CTL_WB, 32'h30C);
    step();
    chk("idv_valid", bus.ex_valid, 0);
    chk("idv_wb", bus.ex_wb_en, 0);

    // flush does not block the flag write of the EX instruction
    drive(1'b1, COND_AL, EX_CMP, CTL_S, 32'h310);
    step();
    chk("fsw_pre_s", bus.ex_s, 1);
    bus.flush = 1'b1;
    bus.alu_status = 4'b1001;
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h314);
    step();
    chk("fsw_valid", bus.ex_valid, 0);
    chk("fsw_status", bus.status, 32'h9);
    bus.flush = 1'b0;

    // stall + flush holds previous contents
    drive(1'b1, COND_AL, EX_ADD, CTL_WB, 32'h400);
    step();
    chk("sf_pre_pc", bus.ex_pc, 32'h400);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drive(1'b1, COND_AL, EX_SUB, CTL_WB, 32'h500);
    step();
    chk("sf_valid", bus.ex_valid, 1);
    chk("sf_pc", bus.ex_pc, 32'h400);
    chk("sf_cmd", bus.ex_ex_cmd, 32'h2);
    chk("sf_wb", bus.ex_wb_en, 1);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // full condition sweep against NZCV = 1001 (EX holds non-S ADD)
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 4'(c), EX_ADD, CTL_WB, 32'h600 + 32'(4 * c));
      #1;
      chk($sformatf("tab_pass_%0d", c), bus.cond_pass, 32'(exp_tab[c]));
      step();
      chk($sformatf("tab_valid_%0d", c), bus.ex_valid, 32'(exp_tab[c]));
      chk($sformatf("tab_wb_%0d", c), bus.ex_wb_en, 32'(exp_tab[c]));
    end
    chk("tab_status", bus.status, 32'h9);

    // back-to-back S instructions; second forwards over the first
    drive(1'b1, COND_AL, EX_CMP, CTL_S, 32'h700);
    step();
    chk("b2b_s1", bus.ex_s, 1);
    chk("b2b_st0", bus.status, 32'h9);
    bus.alu_status = 4'b0110;
    drive(1'b1, COND_AL, EX_CMP, CTL_S, 32'h704);
    step();
    chk("b2b_st1", bus.status, 32'h6);
    chk("b2b_pc", bus.ex_pc, 32'h704);
    bus.alu_status = 4'b0001;
    drive(1'b1, COND_VS, EX_MOV, CTL_WB, 32'h708);
    #1;
    chk("b2b_pass", bus.cond_pass, 1);
    step();
    chk("b2b_st2", bus.status, 32'h1);
    chk("b2b_valid", bus.ex_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
